vit_out_byte_packer: RTL and testbench
======================================

Name: vit_out_byte_packer

Overview:
Downstream neighbour of the Viterbi core. It consumes the core's serial decoded-bit stream (data_serial/valid_serial), packs the bits LSB-first into OUT_W-bit words, and buffers those words in a small FIFO. Words leave through a valid/ready interface to the host/SIPO side. The core cannot be stalled, so FIFO overflow is flagged rather than back-pressured.

Parameters:
OUT_W, 8, packed word width in bits (>=2)
DEPTH, 4, FIFO depth in words (power of 2, >=2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset; synchronous, active-low
data_serial_i  input  1  decoded bit from core
valid_serial_i  input  1  data_serial_i valid this cycle
flush_i  input  1  single-cycle pulse: emit the partial word
data_o  output  OUT_W  head-of-FIFO word
len_o  output  $clog2(OUT_W)+1  valid bit count of data_o, 1..OUT_W
valid_o  output  1  FIFO non-empty
ready_i  input  1  consumer accepts data_o when valid_o && ready_i
level_o  output  $clog2(DEPTH)+1  words currently stored, 0..DEPTH
ovf_o  output  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset (rst_n low at an edge): bit counter=0, shift register=0, FIFO empty. Outputs data_o=0, len_o=0, valid_o=0, level_o=0, ovf_o=0. A partial word held at reset is discarded. Reset mid-stream is legal; packing restarts at bit 0 on the first valid bit after release.
- Packing: each cycle with valid_serial_i=1, the bit goes to position cnt (first bit = bit 0), then cnt increments. Cycles with valid_serial_i=0 change nothing; gaps of any length are allowed.
- Word complete: when the bit at position OUT_W-1 is accepted, a push request is issued with len=OUT_W. cnt returns to 0 and the shift register clears on the same edge.
- flush_i:
  - If cnt>0 (after including a coincident valid bit), push the partial word with upper bits zero-padded and len=cnt. cnt and the shift register then clear.
  - If cnt==0, nothing happens.
  - If the coincident bit completes a word, exactly one push occurs, with len=OUT_W. No empty word is ever pushed.
- FIFO: registered, first-in first-out.
  - data_o/len_o always show the head entry; both are 0 when empty.
  - valid_o = (level_o != 0).
  - A pushed word is visible on valid_o/data_o in the cycle after the edge that sampled its last bit (1-cycle latency).
- Handshake: a pop occurs on an edge where valid_o && ready_i. data_o/len_o stay stable while valid_o=1 and ready_i=0. ready_i is ignored when valid_o=0.
- Simultaneous push and pop:
  - Allowed at any level, including full: level_o is unchanged and no drop occurs.
  - When empty, a push alone gives level 1; pushed data never bypasses the register.
- Overflow: a push at level_o==DEPTH without a simultaneous pop drops the new word. Stored data is untouched and ovf_o is set. ovf_o clears only on reset.
- Pointers wrap modulo DEPTH. level_o is kept as a separate counter: +1 on push-only, -1 on pop-only.
- No combinational path from any input to any output except through FIFO state; all outputs are registered or derived from registers.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with random inputs -> data_o=0, len_o=0, valid_o=0, level_o=0, ovf_o=0.
2. Back-to-back bits 1,0,1,1,0,0,1,0 with ready_i=1 -> one cycle after the 8th bit: valid_o=1, data_o=8'h4D, len_o=8. Popped on the next edge, then level_o=0.
3. Same 8 bits with valid_serial_i gaps of 0–3 cycles -> identical single word 8'h4D, len 8. Nothing emitted before the 8th bit.
4. Bits 1,1,0 then flush_i -> data_o=8'h03, len_o=3. A second flush with cnt=0 produces no word. flush_i coincident with the 8th bit of 8'hFF yields exactly one word, 8'hFF len 8.
5. ready_i=0, push 5 full words 8'h01..8'h05 -> level_o=4, ovf_o=1. Then ready_i=1 drains 8'h01..8'h04 in order and ovf_o stays 1. At level 4, a simultaneous push+pop leaves level 4 and ovf unchanged.
6. Feed 5 bits, assert rst_n=0 for one cycle, then feed 8'hA5 LSB-first -> the only word output is 8'hA5, len 8. The pre-reset partial bits never appear.

Source files
------------

// File: rtl/vit_out_byte_packer.sv
// Output byte packer for the Viterbi core.
// Collects the serial decoded-bit stream LSB-first into OUT_W-bit words and
// queues them in a small FIFO for the host side. The core upstream cannot be
// stalled, so a word arriving at a full FIFO is dropped and ovf_o latches.

module vit_out_byte_packer #(
    parameter int OUT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     data_serial_i,
    input  logic                     valid_serial_i,
    input  logic                     flush_i,
    output logic [OUT_W-1:0]         data_o,
    output logic [$clog2(OUT_W):0]   len_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     ovf_o
);

    localparam int CW = $clog2(OUT_W);
    localparam int LW = CW + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int VW = PW + 1;

    // ------------------------------------------------------------------
    // Packer state
    // ------------------------------------------------------------------
    logic [CW-1:0]    cnt;
    logic [OUT_W-1:0] shreg;

    logic [OUT_W-1:0] bit_vec;
    logic [OUT_W-1:0] word_now;
    logic             last_bit;
    logic             push;
    logic [LW-1:0]    push_len;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] mem_data [DEPTH];
    logic [LW-1:0]    mem_len  [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [VW-1:0]    level;
    logic             ovf;

    logic             full;
    logic             pop;
    logic             wr_en;

    // Word assembly: the incoming bit is merged at position cnt so that a
    // completing bit or a coincident flush sees the whole word this cycle.
    always_comb begin
        bit_vec  = OUT_W'(data_serial_i) << cnt;
        word_now = valid_serial_i ? (shreg | bit_vec) : shreg;
        last_bit = valid_serial_i && (cnt == CW'(OUT_W - 1));
        // A flush only pushes if at least one bit is held after this cycle;
        // if the coincident bit completes the word, last_bit already covers it.
        push     = last_bit || (flush_i && ((cnt != '0) || valid_serial_i));
        if (last_bit) begin
            push_len = LW'(OUT_W);
        end else begin
            push_len = LW'(cnt) + LW'(valid_serial_i);
        end
    end

    // Bit counter and shift register; cleared whenever a word is pushed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (push) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (valid_serial_i) begin
            cnt   <= cnt + CW'(1);
            shreg <= word_now;
        end
    end

    // FIFO control: a pop frees the head slot on the same edge, so a push at
    // full is accepted when paired with a pop (write lands on the old head).
    always_comb begin
        full  = (level == VW'(DEPTH));
        pop   = valid_o && ready_i;
        wr_en = push && (!full || pop);
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_data[wr_ptr] <= word_now;
            mem_len[wr_ptr]  <= push_len;
        end
    end

    // Pointers, occupancy counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   level <= level + VW'(1);
                2'b01:   level <= level - VW'(1);
                default: level <= level;
            endcase
            if (push && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Outputs are derived from registered FIFO state only; zero when empty.
    always_comb begin
        valid_o = (level != '0);
        data_o  = valid_o ? mem_data[rd_ptr] : '0;
        len_o   = valid_o ? mem_len[rd_ptr]  : '0;
        level_o = level;
        ovf_o   = ovf;
    end

endmodule

// File: tb/tb_vit_out_byte_packer.sv
// Directed bench for vit_out_byte_packer with a word scoreboard.

module tb_vit_out_byte_packer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_serial_i = 1'b0;
    logic       valid_serial_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [7:0] data_o;
    logic [3:0] len_o;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic [2:0] level_o;
    logic       ovf_o;

    int n_cmp = 0;
    int n_err = 0;

    // Expected words: [11:8] length, [7:0] data.
    logic [11:0] sb_q [$];

    // Bench reference model of the packer.
    int         mdl_cnt = 0;
    logic [7:0] mdl_sr  = 8'h00;
    bit         accept  = 1'b1;

    vit_out_byte_packer #(.OUT_W(8), .DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_serial_i  (data_serial_i),
        .valid_serial_i (valid_serial_i),
        .flush_i        (flush_i),
        .data_o         (data_o),
        .len_o          (len_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .level_o        (level_o),
        .ovf_o          (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [7:0] d, input int len);
        if (accept) sb_q.push_back({len[3:0], d});
    endtask

    task automatic send_bit(input logic b, input logic fl);
        data_serial_i  = b;
        valid_serial_i = 1'b1;
        flush_i        = fl;
        mdl_sr[mdl_cnt] = b;
        mdl_cnt++;
        if (mdl_cnt == 8) begin
            sb_push(mdl_sr, 8);
            mdl_cnt = 0;
            mdl_sr  = 8'h00;
        end else if (fl) begin
            sb_push(mdl_sr, mdl_cnt);
            mdl_cnt = 0;
            mdl_sr  = 8'h00;
        end
        tick();
        valid_serial_i = 1'b0;
        flush_i        = 1'b0;
        data_serial_i  = 1'b0;
    endtask

    task automatic flush_only();
        flush_i = 1'b1;
        if (mdl_cnt > 0) begin
            sb_push(mdl_sr, mdl_cnt);
            mdl_cnt = 0;
            mdl_sr  = 8'h00;
        end
        tick();
        flush_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap_max);
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i], 1'b0);
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
        end
    endtask

    // Scoreboard: every edge that will pop a word is checked just before it.
    always @(negedge clk) begin
        logic [11:0] e;
        if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_word_valid", 32'(valid_o), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", 32'(data_o), 32'(e[7:0]));
                check("sb_len",  32'(len_o),  32'(e[11:8]));
            end
        end
    end

    initial begin
        // 1: reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_serial_i  = 1'($urandom_range(1, 0));
            valid_serial_i = 1'($urandom_range(1, 0));
            flush_i        = 1'($urandom_range(1, 0));
            ready_i        = 1'($urandom_range(1, 0));
            tick();
        end
        check("rst_data",  32'(data_o),  32'd0);
        check("rst_len",   32'(len_o),   32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_ovf",   32'(ovf_o),   32'd0);
        data_serial_i  = 1'b0;
        valid_serial_i = 1'b0;
        flush_i        = 1'b0;
        ready_i        = 1'b1;
        rst_n          = 1'b1;
        tick();

        // 2: back-to-back 1,0,1,1,0,0,1,0
        send_byte(8'h4D, 0);
        check("t2_valid", 32'(valid_o), 32'd1);
        check("t2_data",  32'(data_o),  32'h4D);
        check("t2_len",   32'(len_o),   32'd8);
        tick();
        check("t2_level_after_pop", 32'(level_o), 32'd0);

        // 3: same bits with gaps
        for (int i = 0; i < 7; i++) begin
            send_bit(i[0] ? ((8'h4D >> i) & 8'h01) != 0 : ((8'h4D >> i) & 8'h01) != 0, 1'b0);
            repeat ($urandom_range(3, 0)) tick();
        end
        check("t3_no_early_word", 32'(valid_o), 32'd0);
        send_bit(1'b0, 1'b0);
        check("t3_data", 32'(data_o), 32'h4D);
        check("t3_len",  32'(len_o),  32'd8);
        tick();

        // 4: partial flush, empty flush, flush with completing bit
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        flush_only();
        check("t4_part_data", 32'(data_o), 32'h03);
        check("t4_part_len",  32'(len_o),  32'd3);
        tick();
        flush_only();
        tick();
        check("t4_empty_flush_level", 32'(level_o), 32'd0);
        for (int i = 0; i < 8; i++) send_bit(1'b1, i == 7);
        check("t4_ff_level", 32'(level_o), 32'd1);
        check("t4_ff_data",  32'(data_o),  32'hFF);
        check("t4_ff_len",   32'(len_o),   32'd8);
        tick();
        check("t4_ff_single", 32'(level_o), 32'd0);

        // 5: overflow, then push+pop at full
        ready_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            accept = (k <= 4);
            send_byte(8'(k), 0);
        end
        accept = 1'b1;
        check("t5_level_full", 32'(level_o), 32'd4);
        check("t5_ovf",        32'(ovf_o),   32'd1);
        check("t5_head_stable", 32'(data_o), 32'h01);
        for (int i = 0; i < 7; i++) send_bit(((8'h06 >> i) & 8'h01) != 0, 1'b0);
        ready_i = 1'b1;
        send_bit(1'b0, 1'b0);
        check("t5_pushpop_level", 32'(level_o), 32'd4);
        check("t5_pushpop_ovf",   32'(ovf_o),   32'd1);
        check("t5_pushpop_head",  32'(data_o),  32'h02);
        repeat (4) tick();
        check("t5_drained_level", 32'(level_o), 32'd0);
        check("t5_ovf_sticky",    32'(ovf_o),   32'd1);

        // 6: reset mid-word discards the partial bits
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        mdl_cnt = 0;
        mdl_sr  = 8'h00;
        check("t6_ovf_cleared", 32'(ovf_o),   32'd0);
        check("t6_level_reset", 32'(level_o), 32'd0);
        send_byte(8'hA5, 0);
        check("t6_data", 32'(data_o), 32'hA5);
        check("t6_len",  32'(len_o),  32'd8);
        repeat (3) tick();
        check("t6_level_end", 32'(level_o), 32'd0);
        check("sb_all_consumed", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
